// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, multiply/divide op select and
// the muldiv sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } md_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   a_i, b_i     operands
//   alu_code_i   operation (ALU_ADD / ALU_SUB / ALU_AND / ALU_OR)
//   result_o     result word
//   carry_o      carry out of ADD, borrow out of SUB, 0 otherwise
//   is_zero_o    result_o == 0
module alu import cpu_pkg::*; #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [2:0]       alu_code_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o,
  output logic             is_zero_o
);

  logic [Width:0] ext;

  always_comb begin
    ext = '0;
    case (alu_code_i)
      ALU_ADD: ext = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB: ext = {1'b0, a_i} - {1'b0, b_i};
      ALU_AND: ext = {1'b0, a_i & b_i};
      ALU_OR:  ext = {1'b0, a_i | b_i};
      default: ext = {1'b0, a_i};
    endcase
  end

  assign result_o  = ext[Width-1:0];
  assign carry_o   = ext[Width];
  assign is_zero_o = (ext[Width-1:0] == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer.
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i, op_i     request pulse and op (MD_MUL / MD_DIV), taken in idle only
//   a_i, b_i          multiplicand/dividend and multiplier/divisor
//   busy_o            high while running or done
//   done_o            one-cycle completion pulse
//   res_lo_o/res_hi_o product low/high, or quotient/remainder
//   div0_o, zero_o    divide-by-zero and all-zero result flags, valid with done
module muldiv_seq import cpu_pkg::*; #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] res_lo_o,
  output logic [Width-1:0] res_hi_o,
  output logic             div0_o,
  output logic             zero_o
);

  localparam int unsigned CntW = $clog2(Width);

  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            op_q, op_d;
  logic [Width-1:0] hi_q, hi_d;    // acc (MUL) / rem (DIV)
  logic [Width-1:0] lo_q, lo_d;    // q for both ops
  logic [Width-1:0] opb_q, opb_d;  // m (MUL) / d (DIV)
  logic             busy_q, busy_d, done_q, done_d;
  logic [Width-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             div0_q, div0_d, zero_q, zero_d;

  logic [Width-1:0] alu_a, alu_res;
  logic [2:0]       alu_code;
  logic             alu_carry, unused_alu_zero;
  logic [Width:0]   div_s;
  logic             div_ge;
  logic [2*Width:0] mul_cat;
  logic             unused_mul_lsb;

  assign div_s    = {hi_q, lo_q[Width-1]};
  assign div_ge   = div_s[Width] | (div_s[Width-1:0] >= opb_q);
  assign alu_code = (op_q == MD_DIV) ? ALU_SUB : ALU_ADD;
  assign alu_a    = (op_q == MD_DIV) ? div_s[Width-1:0] : hi_q;

  alu #(
    .Width(Width)
  ) u_alu (
    .a_i       (alu_a),
    .b_i       (opb_q),
    .alu_code_i(alu_code),
    .result_o  (alu_res),
    .carry_o   (alu_carry),
    .is_zero_o (unused_alu_zero)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    opb_d          = opb_q;
    res_lo_d       = res_lo_q;
    res_hi_d       = res_hi_q;
    div0_d         = div0_q;
    mul_cat        = '0;
    unused_mul_lsb = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (op_i == MD_DIV && b_i == '0) begin
            state_d  = StDone;
            res_lo_d = '1;
            res_hi_d = a_i;
            div0_d   = 1'b1;
          end else begin
            state_d = StRun;
            op_d    = op_i;
            hi_d    = '0;
            lo_d    = a_i;
            opb_d   = b_i;
            cnt_d   = CntW'(Width - 1);
          end
        end
      end
      StRun: begin
        if (op_q == MD_MUL) begin
          // 33-bit {carry, acc/sum, q}; dropping the LSB is the right shift.
          mul_cat = lo_q[0] ? {alu_carry, alu_res, lo_q} : {1'b0, hi_q, lo_q};
          {hi_d, lo_d, unused_mul_lsb} = mul_cat;
        end else begin
          hi_d = div_ge ? alu_res : div_s[Width-1:0];
          lo_d = {lo_q[Width-2:0], div_ge};
        end
        if (cnt_q == '0) begin
          state_d  = StDone;
          res_lo_d = lo_d;
          res_hi_d = hi_d;
          div0_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    zero_d = (res_lo_d == '0) && (res_hi_d == '0);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      div0_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      div0_q   <= div0_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign res_lo_o = res_lo_q;
  assign res_hi_o = res_hi_q;
  assign div0_o   = div0_q;
  assign zero_o   = zero_q;

endmodule
